// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and constants for the branch predictor
// Purpose: BTB entry layout, sweep FSM states, 2-bit counter encodings, PC helper.
// Ports: none (package).
package branch_predictor_pkg;

    localparam int PC_W      = 32;
    // Entry tags are stored zero-extended to this width; unused upper bits are constant.
    localparam int TAG_MAX_W = 32;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [PC_W-1:0]      target;
        logic [1:0]           ctr;
    } btb_entry_t;

    // Sequential next PC; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/resolve/control bundle between pipeline and predictor
// Purpose: groups fetch lookup, execute training, redirect and sweep-control signals.
// Ports (slave view = predictor):
//   in : flush_tables, fetch_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
//        upd_taken, upd_target, upd_pred_taken, upd_pred_target
//   out: busy, pred_taken, pred_target, mispredict, redirect_pc
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic            flush_tables;
    logic            busy;
    logic [PC_W-1:0] fetch_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_is_branch;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_pred_taken;
    logic [PC_W-1:0] upd_pred_target;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output flush_tables, fetch_pc,
        output upd_valid, upd_pc, upd_is_branch, upd_is_jump,
        output upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  busy, pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  flush_tables, fetch_pc,
        input  upd_valid, upd_pc, upd_is_branch, upd_is_jump,
        input  upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output busy, pred_taken, pred_target, mispredict, redirect_pc
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - combinational 2-bit saturating up/down counter
// Purpose: next value of a branch direction counter.
// Ports: ctr (current value), inc (1 = count up, 0 = count down), ctr_next (result).
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict redirect
// Purpose: same-cycle taken/target prediction for fetch_pc, training from resolved
//          instructions, registered mispredict/redirect, and a table-clear sweep.
// Ports: clk, rst_n (async, active-low), bp (branch_predictor_if.slave):
//   fetch_pc -> pred_taken/pred_target (combinational)
//   upd_*    -> table training and mispredict/redirect_pc (registered)
//   flush_tables -> restart sweep; busy high while sweeping
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);

    localparam int              IDX_W    = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

    // Only valid carries a reset; the rest is plain storage initialised by the sweep.
    logic                 valid_q  [ENTRIES];
    logic [TAG_MAX_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]      target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            INIT: begin
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (sweep_idx_q == LAST_IDX) state_d = READY;
            end
            READY: begin
                state_d = READY;
            end
            default: state_d = INIT;
        endcase
        if (bp.flush_tables) begin
            state_d     = INIT;
            sweep_idx_d = '0;
        end
    end

    assign bp.busy = (state_q == INIT);

    // ---------------- predict ----------------
    logic [IDX_W-1:0]     f_idx;
    logic [TAG_MAX_W-1:0] f_tag;
    logic                 f_hit;
    logic                 pred_taken;

    assign f_idx      = bp.fetch_pc[2 +: IDX_W];
    assign f_tag      = TAG_MAX_W'(bp.fetch_pc[2 + IDX_W +: TAG_W]);
    assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken = (state_q == READY) && f_hit && ctr_q[f_idx][1];

    assign bp.pred_taken  = pred_taken;
    assign bp.pred_target = pred_taken ? target_q[f_idx] : pc_plus4(bp.fetch_pc);

    // ---------------- train ----------------
    logic [IDX_W-1:0]     u_idx;
    logic [TAG_MAX_W-1:0] u_tag;
    logic                 u_hit;
    logic [1:0]           u_ctr_next;

    assign u_idx = bp.upd_pc[2 +: IDX_W];
    assign u_tag = TAG_MAX_W'(bp.upd_pc[2 + IDX_W +: TAG_W]);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    branch_predictor_sat_counter2 u_ctr (
        .ctr      (ctr_q[u_idx]),
        .inc      (bp.upd_taken),
        .ctr_next (u_ctr_next)
    );

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    btb_entry_t       wr_entry;

    // Single write port shared by the sweep and training; training is ignored in INIT.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = u_idx;
        wr_entry = '{valid: 1'b0, tag: u_tag, target: bp.upd_target, ctr: ctr_q[u_idx]};
        if (state_q == INIT) begin
            wr_en        = 1'b1;
            wr_idx       = sweep_idx_q;
            wr_entry.ctr = CTR_WNT;
        end else if (bp.upd_valid) begin
            if (bp.upd_is_jump) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b1;
                wr_entry.ctr   = CTR_ST;
            end else if (bp.upd_is_branch) begin
                if (u_hit) begin
                    wr_en          = 1'b1;
                    wr_entry.valid = 1'b1;
                    wr_entry.ctr   = u_ctr_next;
                end else if (bp.upd_taken) begin
                    wr_en          = 1'b1;
                    wr_entry.valid = 1'b1;
                    wr_entry.ctr   = CTR_WT;
                end
            end else if (u_hit) begin
                // A non-control instruction matched: the entry is an alias, drop it.
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_entry.tag;
            target_q[wr_idx] <= wr_entry.target;
            ctr_q[wr_idx]    <= wr_entry.ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_entry.valid;
        end
    end

    // ---------------- mispredict ----------------
    logic            act_taken;
    logic [PC_W-1:0] act_next;
    logic            miss;
    logic            mispredict_q;
    logic [PC_W-1:0] redirect_pc_q;

    assign act_taken = bp.upd_is_jump | (bp.upd_is_branch & bp.upd_taken);
    assign act_next  = act_taken ? bp.upd_target : pc_plus4(bp.upd_pc);
    assign miss      = bp.upd_valid &&
                       ((bp.upd_pred_taken != act_taken) ||
                        (act_taken && (bp.upd_pred_target != bp.upd_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            mispredict_q <= miss;
            if (bp.upd_valid) redirect_pc_q <= act_next;
        end
    end

    assign bp.mispredict  = mispredict_q;
    assign bp.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(64), .TAG_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One clock; strobes are cleared just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bp_if.upd_valid    = 1'b0;
        bp_if.flush_tables = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bp_if.fetch_pc = pc;
        #1;
    endtask

    task automatic set_upd(input logic is_br, input logic is_j, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bp_if.upd_valid       = 1'b1;
        bp_if.upd_is_branch   = is_br;
        bp_if.upd_is_jump     = is_j;
        bp_if.upd_taken       = tk;
        bp_if.upd_pc          = pc;
        bp_if.upd_target      = tgt;
        bp_if.upd_pred_taken  = ptk;
        bp_if.upd_pred_target = ptgt;
    endtask

    task automatic upd(input logic is_br, input logic is_j, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        set_upd(is_br, is_j, tk, pc, tgt, ptk, ptgt);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bp_if.flush_tables    = 1'b0;
        bp_if.fetch_pc        = 32'h0;
        bp_if.upd_valid       = 1'b0;
        bp_if.upd_pc          = 32'h0;
        bp_if.upd_is_branch   = 1'b0;
        bp_if.upd_is_jump     = 1'b0;
        bp_if.upd_taken       = 1'b0;
        bp_if.upd_target      = 32'h0;
        bp_if.upd_pred_taken  = 1'b0;
        bp_if.upd_pred_target = 32'h0;

        // Reset state
        tick();
        tick();
        fetch(32'h100);
        check("rst_busy", bp_if.busy, 1);
        check("rst_misp", bp_if.mispredict, 0);
        check("rst_redir", bp_if.redirect_pc, 0);
        check("rst_pred", bp_if.pred_taken, 0);

        // Initial sweep: 64 cycles busy, no predictions
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            fetch(32'h100 + 32'(i * 4));
            check("sweep_busy", bp_if.busy, 1);
            check("sweep_pred", bp_if.pred_taken, 0);
            tick();
        end
        check("sweep_done", bp_if.busy, 0);

        // Jump training; same-cycle fetch sees old contents
        set_upd(0, 1, 0, 32'h100, 32'h400, 0, 32'h0);
        fetch(32'h100);
        check("jmp_same_cycle", bp_if.pred_taken, 0);
        tick();
        check("jmp_misp", bp_if.mispredict, 1);
        check("jmp_redir", bp_if.redirect_pc, 32'h400);
        fetch(32'h100);
        check("jmp_pred", bp_if.pred_taken, 1);
        check("jmp_tgt", bp_if.pred_target, 32'h400);
        fetch(32'h104);
        check("seq_pred", bp_if.pred_taken, 0);
        check("seq_tgt", bp_if.pred_target, 32'h108);
        tick();
        check("misp_one_cycle", bp_if.mispredict, 0);

        // Branch at 0x200 (same index as 0x100) taken, predicted not-taken
        upd(1, 0, 1, 32'h200, 32'h180, 0, 32'h0);
        check("br_misp", bp_if.mispredict, 1);
        check("br_redir", bp_if.redirect_pc, 32'h180);
        fetch(32'h200);
        check("br_pred", bp_if.pred_taken, 1);
        check("br_tgt", bp_if.pred_target, 32'h180);
        fetch(32'h100);
        check("evicted_pred", bp_if.pred_taken, 0);

        // Correct predictions; counter 2 -> 3 -> 3
        upd(1, 0, 1, 32'h200, 32'h180, 1, 32'h180);
        check("br_ok_misp", bp_if.mispredict, 0);
        upd(1, 0, 1, 32'h200, 32'h180, 1, 32'h180);
        check("br_ok2_misp", bp_if.mispredict, 0);

        // Not-taken x2, back-to-back misses; 3 -> 2 -> 1
        upd(1, 0, 0, 32'h200, 32'h180, 1, 32'h180);
        check("nt1_misp", bp_if.mispredict, 1);
        check("nt1_redir", bp_if.redirect_pc, 32'h204);
        fetch(32'h200);
        check("nt1_pred", bp_if.pred_taken, 1);
        upd(1, 0, 0, 32'h200, 32'h180, 1, 32'h180);
        check("nt2_misp", bp_if.mispredict, 1);
        fetch(32'h200);
        check("nt2_pred", bp_if.pred_taken, 0);
        check("nt2_tgt", bp_if.pred_target, 32'h204);

        // Saturate at 0: 1 -> 0 -> 0 -> 1
        upd(1, 0, 0, 32'h200, 32'h180, 0, 32'h0);
        check("nt3_misp", bp_if.mispredict, 0);
        upd(1, 0, 0, 32'h200, 32'h180, 0, 32'h0);
        upd(1, 0, 1, 32'h200, 32'h180, 0, 32'h0);
        check("tk_after_sat_misp", bp_if.mispredict, 1);
        fetch(32'h200);
        check("sat0_pred", bp_if.pred_taken, 0);

        // Right direction, wrong target
        upd(1, 0, 1, 32'h200, 32'h180, 1, 32'h500);
        check("wrong_tgt_misp", bp_if.mispredict, 1);
        check("wrong_tgt_redir", bp_if.redirect_pc, 32'h180);

        // Aliasing: non-branch hitting a jump entry invalidates it
        upd(0, 1, 0, 32'h100, 32'h400, 0, 32'h0);
        fetch(32'h100);
        check("alias_trained", bp_if.pred_taken, 1);
        upd(0, 0, 0, 32'h100, 32'h0, 1, 32'h400);
        check("alias_misp", bp_if.mispredict, 1);
        check("alias_redir", bp_if.redirect_pc, 32'h104);
        fetch(32'h100);
        check("alias_pred", bp_if.pred_taken, 0);
        check("alias_tgt", bp_if.pred_target, 32'h104);

        // PC wrap
        fetch(32'hFFFF_FFFC);
        check("wrap_tgt", bp_if.pred_target, 32'h0);
        upd(0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
        check("wrap_misp", bp_if.mispredict, 0);
        check("wrap_redir", bp_if.redirect_pc, 32'h0);

        // Flush from READY, then restart mid-sweep at index 30
        upd(0, 1, 0, 32'h1F0, 32'h800, 0, 32'h0);
        fetch(32'h1F0);
        check("pre_flush_pred", bp_if.pred_taken, 1);
        check("pre_flush_tgt", bp_if.pred_target, 32'h800);
        bp_if.flush_tables = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            fetch(32'h1F0);
            check("flush_busy", bp_if.busy, 1);
            check("flush_pred", bp_if.pred_taken, 0);
            tick();
        end
        bp_if.flush_tables = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            if (i == 2) set_upd(0, 1, 0, 32'h300, 32'h600, 0, 32'h0);
            check("reflush_busy", bp_if.busy, 1);
            tick();
        end
        check("reflush_done", bp_if.busy, 0);
        fetch(32'h300);
        check("drop_upd_pred", bp_if.pred_taken, 0);
        fetch(32'h1F0);
        check("cleared_pred", bp_if.pred_taken, 0);

        // Asynchronous reset mid-operation
        upd(0, 0, 0, 32'h40, 32'h0, 1, 32'h900);
        check("pre_rst_misp", bp_if.mispredict, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_misp", bp_if.mispredict, 0);
        check("async_rst_redir", bp_if.redirect_pc, 0);
        check("async_rst_busy", bp_if.busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor that answers, in the same cycle, whether the instruction at the fetch PC is a taken control transfer and where it goes. Execute-stage branch resolution (taken/not-taken plus target) trains it. The block is a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It also compares each resolved outcome against the prediction that travelled down the pipe and produces a registered mispredict/redirect pulse for the fetch stage. A sweep state machine clears the tables after reset or on demand.

## Interface
- `ENTRIES`, 64: number of BTB entries; power of two, ≥ 2. `IDX_W = $clog2(ENTRIES)`.
- `TAG_W`, 10: tag width. Tag is `pc[2+IDX_W +: TAG_W]`; index is `pc[2 +: IDX_W]`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_tables` in 1: restart the table clear sweep.
- `busy` out 1: high while sweeping.
- `fetch_pc` in 32: PC being fetched.
- `pred_taken` out 1: combinational prediction for `fetch_pc`.
- `pred_target` out 32: predicted next PC. Equals `fetch_pc+4` when `pred_taken` = 0.
- `upd_valid` in 1: a resolved instruction is presented this cycle.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_is_branch` in 1: conditional branch.
- `upd_is_jump` in 1: JAL/JALR.
- `upd_taken` in 1: branch condition result from execute.
- `upd_target` in 32: computed target.
- `upd_pred_taken` in 1: prediction carried with the instruction.
- `upd_pred_target` in 32: prediction carried with the instruction.
- `mispredict` out 1: registered one-cycle pulse.
- `redirect_pc` out 32: registered correct next PC, valid with `mispredict`.

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[32]`, `ctr[2]`. Storage may be distributed RAM; only `valid` needs a reset or sweep clear.
- States are `INIT` and `READY`.
  - Reset puts the block in `INIT` with `sweep_idx` = 0.
  - In `INIT`, each cycle writes `valid` = 0 and `ctr` = 2'b01 at `sweep_idx`, then increments `sweep_idx`.
  - After the write at `ENTRIES-1`, the block moves to `READY`.
  - `flush_tables` in either state forces `INIT` with `sweep_idx` = 0; it restarts the sweep if one is already in progress.
- Predict (`READY` only):
  - `hit` = `valid && tag` match.
  - `pred_taken` = `hit && ctr[1]`.
  - `pred_target` = `pred_taken ? target : fetch_pc+4`.
  - In `INIT`, `pred_taken` = 0.
- Actual outcome:
  - `act_taken` = `upd_is_jump | (upd_is_branch & upd_taken)`.
  - `act_next` = `act_taken ? upd_target : upd_pc+4`.
- Train (`READY && upd_valid`, lookup at `upd_pc`):
  - Jump: write the entry with `valid`=1, tag, target, `ctr`=2'b11.
  - Branch hit: write target; `ctr` increments (saturating at 3) if taken, decrements (saturating at 0) if not.
  - Branch miss and taken: allocate with `ctr`=2'b10 and target, overwriting any occupant.
  - Branch miss and not taken: no write.
  - Neither branch nor jump, on a hit: clear `valid`. This removes an aliased entry.
  - Updates presented in `INIT` are dropped.
- Mispredict check (every state):
  - `miss` = `upd_valid && (upd_pred_taken != act_taken || (act_taken && upd_pred_target != upd_target))`.
  - Registered to `mispredict`; `redirect_pc` <= `act_next` whenever `upd_valid`.
- All PC arithmetic is 32-bit modulo 2^32: `0xFFFFFFFC + 4` = 0.

## Timing
- Reset values: `mispredict`=0, `redirect_pc`=0, `busy`=1, state `INIT`, `sweep_idx`=0. `pred_taken` is 0 throughout `INIT`.
- The sweep lasts exactly `ENTRIES` cycles. `busy` falls on the edge that completes index `ENTRIES-1`.
- Prediction has zero latency: it is combinational from `fetch_pc` and the current table state.
- A table write is visible to predict from the cycle after the `upd_valid` edge. If fetch and update hit the same index in the same cycle, predict sees the old contents.
- `mispredict` is high for exactly one cycle, the cycle after a `miss` cycle. Back-to-back misses give back-to-back pulses.
- Asserting `rst_n` low mid-operation immediately clears the outputs and restarts the sweep on release.

## Structure
- Add to the `RISCV` package:
  - `btb_entry_t` struct.
  - `bp_state_t` enum {`INIT`, `READY`}.
  - Counter constants `CTR_SNT`=0, `CTR_WNT`=1, `CTR_WT`=2, `CTR_ST`=3.
- One natural sub-module is `sat_counter2`: a combinational 2-bit saturating inc/dec.
- The table array, sweep FSM and mispredict register stay in `branch_predictor`.

## Test plan
- Reset, then hold `rst_n`=1 → `busy`=1 for 64 cycles, then 0; `pred_taken`=0 for every `fetch_pc` in the window.
- Jump at 0x100 with target 0x400 trained → next cycle `fetch_pc`=0x100 gives `pred_taken`=1, `pred_target`=0x400; `fetch_pc`=0x104 gives `pred_target`=0x108.
- Branch at 0x200 resolved taken (target 0x180) with `upd_pred_taken`=0 → `mispredict` pulse, `redirect_pc`=0x180. Predicts taken once trained. After two not-taken resolves, predicts not-taken.
- Taken branch with `upd_pred_taken`=1 but `upd_pred_target`=0x500 while `upd_target`=0x180 → `mispredict`=1, `redirect_pc`=0x180. Correct prediction → `mispredict`=0.
- Aliasing: train 0x100 taken, then resolve a non-branch at 0x100 with `upd_pred_taken`=1 → `mispredict`=1, `redirect_pc`=0x104, and the entry is invalidated.
- `flush_tables` pulsed mid-sweep at index 30 → sweep restarts and `busy` stays high 64 more cycles. Updates during the sweep leave no entry behind.
